// File: rtl/br_pkg.sv
// Shared types for the branch resolver: the tracked-branch slot and the
// predictor update bundle.
package br_pkg;

   localparam int PC_W   = 32;
   localparam int PC_INC = 4;

   typedef struct packed {
      logic            valid;
      logic            resolved;
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
      logic            is_call;
      logic            is_ret;
      logic            act_taken;
      logic [PC_W-1:0] act_target;
   } br_entry_t;

   typedef struct packed {
      logic            new_entry;
      logic [PC_W-1:0] pc_orig;
      logic [PC_W-1:0] target_pc;
      logic            is_taken;
      logic            invalidate;
      logic [PC_W-1:0] old_pc;
      logic            is_jumpl;
   } br_update_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch allocation, execute resolution and predictor update signals of the
// branch resolver.
interface branch_resolver_if #(
   parameter int PC_BITS  = 32,
   parameter int DEPTH    = 8,
   parameter int TAG_BITS = $clog2(DEPTH)
);
   logic                alloc_valid;
   logic                alloc_ready;
   logic [PC_BITS-1:0]  alloc_pc;
   logic                alloc_pred_taken;
   logic [PC_BITS-1:0]  alloc_pred_target;
   logic                alloc_is_call;
   logic                alloc_is_ret;
   logic [TAG_BITS-1:0] alloc_tag;
   logic                res_valid;
   logic [TAG_BITS-1:0] res_tag;
   logic                res_taken;
   logic [PC_BITS-1:0]  res_target;
   logic                upd_new_entry;
   logic [PC_BITS-1:0]  upd_pc_orig;
   logic [PC_BITS-1:0]  upd_target_pc;
   logic                upd_is_taken;
   logic                upd_invalidate;
   logic [PC_BITS-1:0]  upd_old_pc;
   logic                upd_is_jumpl;
   logic                branch_resolved;
   logic                must_flush;
   logic [PC_BITS-1:0]  redirect_pc;

   modport slave (
      input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
             alloc_is_call, alloc_is_ret, res_valid, res_tag, res_taken, res_target,
      output alloc_ready, alloc_tag, upd_new_entry, upd_pc_orig, upd_target_pc,
             upd_is_taken, upd_invalidate, upd_old_pc, upd_is_jumpl,
             branch_resolved, must_flush, redirect_pc
   );

   modport master (
      output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
             alloc_is_call, alloc_is_ret, res_valid, res_tag, res_taken, res_target,
      input  alloc_ready, alloc_tag, upd_new_entry, upd_pc_orig, upd_target_pc,
             upd_is_taken, upd_invalidate, upd_old_pc, upd_is_jumpl,
             branch_resolved, must_flush, redirect_pc
   );
endinterface

// File: rtl/br_queue.sv
// In-order circular store of in-flight branches; slots fill at tail, are
// resolved by tag in any order and leave from head.
module br_queue
   import br_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int TAG_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_en,
   input  br_entry_t           alloc_entry,
   output logic [TAG_BITS-1:0] tail,
   output logic [TAG_BITS:0]   count,
   input  logic                res_en,
   input  logic [TAG_BITS-1:0] res_tag,
   input  logic                res_taken,
   input  logic [PC_W-1:0]     res_target,
   output br_entry_t           head_entry,
   input  logic                pop,
   input  logic                clear
);
   br_entry_t             slots_q [DEPTH];
   br_entry_t             slots_d [DEPTH];
   logic [TAG_BITS-1:0]   head_q, head_d, tail_q, tail_d;
   logic [TAG_BITS:0]     count_q, count_d;

   assign head_entry = slots_q[head_q];
   assign tail       = tail_q;
   assign count      = count_q;

   always_comb begin
      slots_d = slots_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_d[i].valid    = 1'b0;
            slots_d[i].resolved = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Late or duplicate outcomes must not disturb a slot.
         if (res_en && slots_q[res_tag].valid && !slots_q[res_tag].resolved) begin
            slots_d[res_tag].resolved   = 1'b1;
            slots_d[res_tag].act_taken  = res_taken;
            slots_d[res_tag].act_target = res_target;
         end
         if (pop) begin
            slots_d[head_q].valid    = 1'b0;
            slots_d[head_q].resolved = 1'b0;
            head_d                   = head_q + TAG_BITS'(1);
         end
         if (alloc_en) begin
            slots_d[tail_q]          = alloc_entry;
            slots_d[tail_q].valid    = 1'b1;
            slots_d[tail_q].resolved = 1'b0;
            tail_d                   = tail_q + TAG_BITS'(1);
         end
         count_d = count_q + (TAG_BITS+1)'(alloc_en) - (TAG_BITS+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         slots_q <= slots_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Retires tracked branches in order, compares prediction against outcome and
// drives the registered predictor update, flush and redirect.
module branch_resolver
   import br_pkg::*;
#(
   parameter int PC_BITS  = PC_W,
   parameter int DEPTH    = 8,
   parameter int TAG_BITS = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              rst_n,
   branch_resolver_if.slave bif
);
   br_entry_t           head, alloc_entry;
   logic [TAG_BITS-1:0] tail;
   logic [TAG_BITS:0]   count;
   logic                commit_now, mispredict, flush_now, alloc_ready;
   logic [PC_BITS-1:0]  seq_pc;

   br_update_t          upd_q, upd_d;
   logic                resolved_q, resolved_d, flush_q, flush_d;
   logic [PC_BITS-1:0]  redirect_q, redirect_d;

   assign commit_now  = head.valid & head.resolved;
   assign mispredict  = (head.pred_taken != head.act_taken) |
                        (head.act_taken & (head.pred_target != head.act_target));
   assign flush_now   = commit_now & mispredict;
   assign alloc_ready = (count != (TAG_BITS+1)'(DEPTH)) & ~flush_now;
   assign seq_pc      = head.pc[PC_BITS-1:0] + PC_BITS'(PC_INC);

   always_comb begin
      alloc_entry             = '0;
      alloc_entry.pc          = PC_W'(bif.alloc_pc);
      alloc_entry.pred_taken  = bif.alloc_pred_taken;
      alloc_entry.pred_target = PC_W'(bif.alloc_pred_target);
      alloc_entry.is_call     = bif.alloc_is_call;
      alloc_entry.is_ret      = bif.alloc_is_ret;
   end

   br_queue #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_en    (bif.alloc_valid & alloc_ready),
      .alloc_entry (alloc_entry),
      .tail        (tail),
      .count       (count),
      .res_en      (bif.res_valid),
      .res_tag     (bif.res_tag),
      .res_taken   (bif.res_taken),
      .res_target  (PC_W'(bif.res_target)),
      .head_entry  (head),
      .pop         (commit_now & ~mispredict),
      .clear       (flush_now)
   );

   // Outputs describe the branch that retired on the previous edge.
   always_comb begin
      upd_d      = '0;
      resolved_d = 1'b0;
      flush_d    = 1'b0;
      redirect_d = '0;
      if (commit_now) begin
         resolved_d       = 1'b1;
         flush_d          = mispredict;
         redirect_d       = head.act_taken ? head.act_target[PC_BITS-1:0] : seq_pc;
         upd_d.new_entry  = ~head.is_ret;
         upd_d.pc_orig    = head.pc;
         upd_d.target_pc  = head.act_target;
         upd_d.is_taken   = head.act_taken;
         upd_d.invalidate = head.pred_taken & ~head.act_taken & ~head.is_ret;
         upd_d.old_pc     = head.pc;
         upd_d.is_jumpl   = head.is_call;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_q      <= '0;
         resolved_q <= 1'b0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
      end else begin
         upd_q      <= upd_d;
         resolved_q <= resolved_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
      end
   end

   assign bif.alloc_ready     = alloc_ready;
   assign bif.alloc_tag       = tail;
   assign bif.branch_resolved = resolved_q;
   assign bif.must_flush      = flush_q;
   assign bif.redirect_pc     = redirect_q;
   assign bif.upd_new_entry   = upd_q.new_entry;
   assign bif.upd_pc_orig     = upd_q.pc_orig[PC_BITS-1:0];
   assign bif.upd_target_pc   = upd_q.target_pc[PC_BITS-1:0];
   assign bif.upd_is_taken    = upd_q.is_taken;
   assign bif.upd_invalidate  = upd_q.invalidate;
   assign bif.upd_old_pc      = upd_q.old_pc[PC_BITS-1:0];
   assign bif.upd_is_jumpl    = upd_q.is_jumpl;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a list-based model of in-flight
// branches predicts every retirement, and a monitor checks each one.
module tb_branch_resolver;
   localparam int DEPTH    = 8;
   localparam int TAG_BITS = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolver_if #(.PC_BITS(32), .DEPTH(DEPTH)) bif ();

   branch_resolver #(.PC_BITS(32), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   typedef struct {
      int          tag;
      logic [31:0] pc, ptg, atg;
      bit          pt, call, ret, res, at;
   } ent_t;

   typedef struct {
      bit          ne, tk, inv, jl, fl;
      logic [31:0] pc, tgt, rd;
   } exp_t;

   ent_t mq[$];
   exp_t exp_q[$];
   int   m_tail = 0;
   int   checks = 0;
   int   errors = 0;

   bit          a_v, a_pt, a_call, a_ret, r_v, r_t;
   logic [31:0] a_pc, a_ptg, r_tg;
   int          r_tag;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic alloc(input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                        input bit call = 1'b0, input bit ret = 1'b0);
      a_v = 1'b1; a_pc = pc; a_pt = pt; a_ptg = ptg; a_call = call; a_ret = ret;
   endtask

   task automatic resolve(input int tag, input bit t, input logic [31:0] tg);
      r_v = 1'b1; r_tag = tag; r_t = t; r_tg = tg;
   endtask

   // Reference: retire the oldest entry once resolved; a wrong direction or
   // wrong taken target empties everything and drops this cycle's requests.
   task automatic model_step();
      bit   commit, mis, ready;
      ent_t e;
      exp_t x;
      commit = (mq.size() > 0) && mq[0].res;
      mis    = commit && ((mq[0].pt != mq[0].at) || (mq[0].at && (mq[0].ptg != mq[0].atg)));
      ready  = (mq.size() < DEPTH) && !mis;
      chk("alloc_ready", 32'(bif.alloc_ready), 32'(ready));
      if (a_v && ready) chk("alloc_tag", 32'(bif.alloc_tag), m_tail);
      if (commit) begin
         e     = mq[0];
         x.ne  = !e.ret;
         x.tk  = e.at;
         x.inv = e.pt && !e.at && !e.ret;
         x.jl  = e.call;
         x.fl  = mis;
         x.pc  = e.pc;
         x.tgt = e.atg;
         x.rd  = e.at ? e.atg : e.pc + 32'd4;
         exp_q.push_back(x);
      end
      if (mis) begin
         mq.delete();
         m_tail = 0;
      end else begin
         if (r_v)
            foreach (mq[i])
               if (mq[i].tag == r_tag && !mq[i].res) begin
                  mq[i].res = 1'b1; mq[i].at = r_t; mq[i].atg = r_tg;
               end
         if (commit) void'(mq.pop_front());
         if (a_v && ready) begin
            e = '{tag: m_tail, pc: a_pc, ptg: a_ptg, atg: 32'd0, pt: a_pt,
                  call: a_call, ret: a_ret, res: 1'b0, at: 1'b0};
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      bif.alloc_valid       = a_v;
      bif.alloc_pc          = a_pc;
      bif.alloc_pred_taken  = a_pt;
      bif.alloc_pred_target = a_ptg;
      bif.alloc_is_call     = a_call;
      bif.alloc_is_ret      = a_ret;
      bif.res_valid         = r_v;
      bif.res_tag           = TAG_BITS'(r_tag);
      bif.res_taken         = r_t;
      bif.res_target        = r_tg;
      #1;
      model_step();
      a_v = 1'b0;
      r_v = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bif.alloc_valid = 1'b0;
      bif.res_valid   = 1'b0;
      a_v = 1'b0;
      r_v = 1'b0;
      #1;
      chk("rst_flags", 32'({bif.branch_resolved, bif.must_flush, bif.upd_new_entry,
                            bif.upd_is_taken, bif.upd_invalidate, bif.upd_is_jumpl}), 0);
      chk("rst_pcs", bif.redirect_pc | bif.upd_pc_orig | bif.upd_target_pc | bif.upd_old_pc, 0);
      chk("rst_ready", 32'(bif.alloc_ready), 1);
      chk("rst_tag", 32'(bif.alloc_tag), 0);
      mq.delete();
      exp_q.delete();
      m_tail = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (bif.branch_resolved) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit: got branch_resolved=1 expected no retirement");
               end else begin
                  x = exp_q.pop_front();
                  chk("upd_new_entry", 32'(bif.upd_new_entry), 32'(x.ne));
                  chk("upd_pc_orig", bif.upd_pc_orig, x.pc);
                  chk("upd_target_pc", bif.upd_target_pc, x.tgt);
                  chk("upd_is_taken", 32'(bif.upd_is_taken), 32'(x.tk));
                  chk("upd_invalidate", 32'(bif.upd_invalidate), 32'(x.inv));
                  chk("upd_old_pc", bif.upd_old_pc, x.pc);
                  chk("upd_is_jumpl", 32'(bif.upd_is_jumpl), 32'(x.jl));
                  chk("must_flush", 32'(bif.must_flush), 32'(x.fl));
                  if (x.fl) chk("redirect_pc", bif.redirect_pc, x.rd);
               end
            end else begin
               chk("idle_flush", 32'(bif.must_flush), 0);
            end
         end
      end
   end

   initial begin
      ent_t e;
      int   idx;
      a_v = 0; a_pt = 0; a_call = 0; a_ret = 0; a_pc = 0; a_ptg = 0;
      r_v = 0; r_t = 0; r_tg = 0; r_tag = 0;
      do_reset();

      // correct not-taken prediction
      alloc(32'h100, 1'b0, 32'h0); step();
      resolve(0, 1'b0, 32'h0); step();
      step();
      step();
      chk("ok_resolved", 32'(bif.branch_resolved), 1);
      chk("ok_taken", 32'(bif.upd_is_taken), 0);
      chk("ok_flush", 32'(bif.must_flush), 0);

      // out-of-order resolve, in-order retire
      do_reset();
      for (int i = 0; i < 3; i++) begin alloc(32'h100 + 32'(i * 4), 1'b0, 32'h0); step(); end
      resolve(2, 1'b0, 32'h0); step();
      resolve(1, 1'b0, 32'h0); step();
      resolve(0, 1'b0, 32'h0); step();
      repeat (4) step();

      // direction mispredict with younger entries; alloc during flush dropped
      do_reset();
      alloc(32'h200, 1'b1, 32'h300); step();
      alloc(32'h210, 1'b0, 32'h0); step();
      alloc(32'h220, 1'b0, 32'h0); step();
      alloc(32'h230, 1'b0, 32'h0); resolve(0, 1'b0, 32'h0); step();
      alloc(32'h240, 1'b0, 32'h0); step();
      step();
      chk("mis_flush", 32'(bif.must_flush), 1);
      chk("mis_redirect", bif.redirect_pc, 32'h204);
      chk("mis_invalidate", 32'(bif.upd_invalidate), 1);
      chk("mis_old_pc", bif.upd_old_pc, 32'h200);
      chk("mis_empty_tag", 32'(bif.alloc_tag), 0);
      chk("mis_ready", 32'(bif.alloc_ready), 1);

      // target mispredict
      do_reset();
      alloc(32'h380, 1'b1, 32'h400); step();
      resolve(0, 1'b1, 32'h480); step();
      step();
      step();
      chk("tgt_flush", 32'(bif.must_flush), 1);
      chk("tgt_redirect", bif.redirect_pc, 32'h480);
      chk("tgt_new_entry", 32'(bif.upd_new_entry), 1);
      chk("tgt_invalidate", 32'(bif.upd_invalidate), 0);

      // fill, simultaneous commit+alloc, wrap, full
      do_reset();
      for (int i = 0; i < 7; i++) begin alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0); step(); end
      resolve(0, 1'b0, 32'h0); step();
      alloc(32'h101c, 1'b0, 32'h0); step();
      chk("wrap_tag7", 32'(bif.alloc_tag), 7);
      alloc(32'h1020, 1'b0, 32'h0); step();
      chk("wrap_tag0", 32'(bif.alloc_tag), 0);
      alloc(32'h1024, 1'b0, 32'h0); step();
      chk("full_ready", 32'(bif.alloc_ready), 0);
      alloc(32'h1024, 1'b0, 32'h0); step();

      // call then return
      do_reset();
      alloc(32'h500, 1'b1, 32'h600, 1'b1, 1'b0); step();
      alloc(32'h504, 1'b1, 32'h700, 1'b0, 1'b1); resolve(0, 1'b1, 32'h600); step();
      resolve(1, 1'b1, 32'h700); step();
      step();
      chk("call_jumpl", 32'(bif.upd_is_jumpl), 1);
      chk("call_old_pc", bif.upd_old_pc, 32'h500);
      step();
      chk("ret_new_entry", 32'(bif.upd_new_entry), 0);

      // reset with entries in flight
      for (int i = 0; i < 3; i++) begin alloc(32'h600 + 32'(i * 4), 1'b0, 32'h0); step(); end
      do_reset();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(9) < 6)
            alloc(32'h4000 + 32'($urandom_range(255) * 4), $urandom_range(1) == 1,
                  32'h8000 + 32'($urandom_range(3) * 16),
                  $urandom_range(7) == 0, $urandom_range(7) == 0);
         if ($urandom_range(9) < 6) begin
            if (mq.size() > 0 && $urandom_range(3) != 0) begin
               idx = int'($urandom_range(mq.size() - 1));
               e   = mq[idx];
               resolve(e.tag, ($urandom_range(4) == 0) ? !e.pt : e.pt,
                       ($urandom_range(4) == 0) ? e.ptg + 32'd16 : e.ptg);
            end else begin
               resolve(int'($urandom_range(DEPTH - 1)), $urandom_range(1) == 1, 32'h8000);
            end
         end
         step();
      end

      repeat (DEPTH + 3) step();
      @(posedge clk);
      #2;
      chk("pending_commits", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
